// File: rtl/preg_freelist_if.sv
// rtl/preg_freelist_if.sv - rename/commit <-> physical register free list signal bundle
interface preg_freelist_if #(
    parameter int PREG_W = 7
);
    logic                   alloc_req;
    logic [2:0]             alloc_num;
    logic                   alloc_grant;
    logic [3:0][PREG_W-1:0] alloc_preg_index_vec;
    logic                   commit_valid;
    logic [3:0]             freed_preg_vec;
    logic [PREG_W-1:0]      freed_preg_index_0;
    logic [PREG_W-1:0]      freed_preg_index_1;
    logic [PREG_W-1:0]      freed_preg_index_2;
    logic [PREG_W-1:0]      freed_preg_index_3;
    logic [2:0]             commit_alloc_num;
    logic                   recover_valid;
    logic [PREG_W-1:0]      free_count;
    logic                   freelist_empty;
    logic                   freelist_full;

    modport master (
        output alloc_req, alloc_num, commit_valid, freed_preg_vec,
               freed_preg_index_0, freed_preg_index_1, freed_preg_index_2, freed_preg_index_3,
               commit_alloc_num, recover_valid,
        input  alloc_grant, alloc_preg_index_vec, free_count, freelist_empty, freelist_full
    );

    modport slave (
        input  alloc_req, alloc_num, commit_valid, freed_preg_vec,
               freed_preg_index_0, freed_preg_index_1, freed_preg_index_2, freed_preg_index_3,
               commit_alloc_num, recover_valid,
        output alloc_grant, alloc_preg_index_vec, free_count, freelist_empty, freelist_full
    );
endinterface

// File: rtl/preg_freelist_ctrl.sv
// rtl/preg_freelist_ctrl.sv - physical register free list with speculative and committed heads
module preg_freelist_ctrl #(
    parameter int PREG_NUM = 128,
    parameter int ARCH_NUM = 32
) (
    input  logic           clk,
    input  logic           rst,
    preg_freelist_if.slave fl
);
    localparam int PREG_W = $clog2(PREG_NUM);
    localparam int CAP    = PREG_NUM - ARCH_NUM;
    localparam logic [PREG_W-1:0] CAP_W  = PREG_W'(CAP);
    localparam logic [PREG_W-1:0] ARCH_W = PREG_W'(ARCH_NUM);
    localparam logic [PREG_W-1:0] ONE_W  = PREG_W'(1);

    logic [PREG_W-1:0] mem_q [PREG_NUM];
    logic [PREG_W-1:0] mem_d [PREG_NUM];
    logic [PREG_W-1:0] spec_head_q, spec_head_d;
    logic [PREG_W-1:0] arch_head_q, arch_head_d;
    logic [PREG_W-1:0] tail_q, tail_d;
    logic [PREG_W-1:0] free_count_q, free_count_d;

    logic [PREG_W-1:0] freed_idx [4];
    logic [PREG_W-1:0] wr_ptr;
    logic [3:0]        rel_low;
    logic              grant;

    always_comb begin
        freed_idx[0] = fl.freed_preg_index_0;
        freed_idx[1] = fl.freed_preg_index_1;
        freed_idx[2] = fl.freed_preg_index_2;
        freed_idx[3] = fl.freed_preg_index_3;
        for (int j = 0; j < 4; j++) begin
            rel_low[j] = fl.freed_preg_vec[j] && (freed_idx[j] < ARCH_W);
        end
    end

    // A flush cycle never grants, so rename cannot consume entries about to be reclaimed.
    always_comb begin
        grant = !rst && fl.alloc_req && !fl.recover_valid
                && (PREG_W'(fl.alloc_num) <= free_count_q);
    end

    assign fl.alloc_grant    = grant;
    assign fl.free_count     = free_count_q;
    assign fl.freelist_empty = (free_count_q == '0);
    assign fl.freelist_full  = (free_count_q == CAP_W);

    for (genvar g = 0; g < 4; g++) begin : g_vec
        assign fl.alloc_preg_index_vec[g] = mem_q[spec_head_q + PREG_W'(g)];
    end

    // Sparse release slots are packed in slot order starting at the tail.
    always_comb begin
        mem_d  = mem_q;
        wr_ptr = tail_q;
        if (fl.commit_valid) begin
            for (int j = 0; j < 4; j++) begin
                if (fl.freed_preg_vec[j]) begin
                    mem_d[wr_ptr] = freed_idx[j];
                    wr_ptr        = wr_ptr + ONE_W;
                end
            end
        end
        tail_d = wr_ptr;
    end

    // Commit is older than the flush, so the flush rewinds to the already-advanced arch head.
    always_comb begin
        arch_head_d = arch_head_q + (fl.commit_valid ? PREG_W'(fl.commit_alloc_num) : '0);
        if (fl.recover_valid) begin
            spec_head_d = arch_head_d;
        end else if (grant) begin
            spec_head_d = spec_head_q + PREG_W'(fl.alloc_num);
        end else begin
            spec_head_d = spec_head_q;
        end
        free_count_d = tail_d - spec_head_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PREG_NUM; i++) begin
                mem_q[i] <= (i < CAP) ? PREG_W'(ARCH_NUM + i) : '0;
            end
            spec_head_q  <= '0;
            arch_head_q  <= '0;
            tail_q       <= CAP_W;
            free_count_q <= CAP_W;
        end else begin
            mem_q        <= mem_d;
            spec_head_q  <= spec_head_d;
            arch_head_q  <= arch_head_d;
            tail_q       <= tail_d;
            free_count_q <= free_count_d;
        end
    end

    a_alloc_num: assert property (@(posedge clk) disable iff (rst)
        fl.alloc_req |-> (fl.alloc_num <= 3'd4));
    a_release_arch: assert property (@(posedge clk) disable iff (rst)
        fl.commit_valid |-> (rel_low == 4'b0000));
    a_overflow: assert property (@(posedge clk) disable iff (rst)
        free_count_d <= CAP_W);
    a_arch_pass: assert property (@(posedge clk) disable iff (rst)
        fl.commit_valid |-> (PREG_W'(fl.commit_alloc_num) <= PREG_W'(spec_head_q - arch_head_q)));
endmodule
